// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the 8x16 data memory: round-robin on ties, a fixed
// IDLE -> ACCESS -> RESP transaction per access, and all outputs registered.
module dmem_arbiter #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              sig_mem_write,
  output logic              sig_mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_last_gnt, w_last_gnt;
  logic                r_we, w_we;
  logic [1:0]          r_gnt, w_gnt;
  logic [1:0]          r_ack, w_ack;
  logic                r_wr, w_wr;
  logic                r_rd, w_rd;
  logic                r_busy, w_busy;
  logic [ADDR_W-1:0]   r_addr, w_addr;
  logic [DATA_W-1:0]   r_wdata, w_wdata;
  logic [DATA_W-1:0]   r_rdata, w_rdata;
  logic                w_win_vld;
  logic                w_win;

  // On a tie the port that did not win last time takes it.
  always_comb begin
    w_win_vld = |req;
    case (req)
      2'b10:   w_win = 1'b1;
      2'b11:   w_win = ~r_last_gnt;
      default: w_win = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_win_vld) w_state_nxt = S_ACCESS;
      S_ACCESS: w_state_nxt = S_RESP;
      S_RESP:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Next values for the registered outputs; strobes and ack land one
  // cycle after the decision so nothing on the memory side sees req directly.
  always_comb begin
    w_gnt      = r_gnt;
    w_ack      = 2'b00;
    w_wr       = 1'b0;
    w_rd       = 1'b0;
    w_we       = r_we;
    w_addr     = r_addr;
    w_wdata    = r_wdata;
    w_rdata    = r_rdata;
    w_last_gnt = r_last_gnt;
    case (r_state)
      S_IDLE: begin
        w_gnt = 2'b00;
        if (w_win_vld) begin
          w_gnt      = w_win ? 2'b10 : 2'b01;
          w_we       = we[w_win];
          w_wr       = we[w_win];
          w_rd       = ~we[w_win];
          w_addr     = w_win ? addr1 : addr0;
          w_wdata    = w_win ? wdata1 : wdata0;
          w_last_gnt = w_win;
        end
      end
      S_ACCESS: begin
        if (!r_we) w_rdata = mem_rdata;
        w_ack = r_gnt;
      end
      S_RESP:  w_gnt = 2'b00;
      default: w_gnt = 2'b00;
    endcase
    w_busy = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_gnt <= 1'b1;
      r_we       <= 1'b0;
      r_gnt      <= 2'b00;
      r_ack      <= 2'b00;
      r_wr       <= 1'b0;
      r_rd       <= 1'b0;
      r_busy     <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
    end else begin
      r_last_gnt <= w_last_gnt;
      r_we       <= w_we;
      r_gnt      <= w_gnt;
      r_ack      <= w_ack;
      r_wr       <= w_wr;
      r_rd       <= w_rd;
      r_busy     <= w_busy;
      r_addr     <= w_addr;
      r_wdata    <= w_wdata;
      r_rdata    <= w_rdata;
    end
  end

  assign gnt           = r_gnt;
  assign ack           = r_ack;
  assign rdata         = r_rdata;
  assign busy          = r_busy;
  assign sig_mem_write = r_wr;
  assign sig_mem_read  = r_rd;
  assign mem_addr      = r_addr;
  assign mem_wdata     = r_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 8x16 memory that
// reloads a fixed image whenever reset is high at a clock edge.
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, we;
  logic [2:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic [1:0]  gnt, ack;
  logic [15:0] rdata;
  logic        busy, sig_mem_write, sig_mem_read;
  logic [2:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;

  logic [15:0] mem [8];
  int n_chk = 0;
  int n_err = 0;
  int bad_gnt = 0;
  int bad_strb = 0;
  int nacks;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(3), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt), .ack(ack), .rdata(rdata), .busy(busy),
    .sig_mem_write(sig_mem_write), .sig_mem_read(sig_mem_read),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) mem[i] <= 16'h0000;
      mem[0] <= 16'h0A0A;
      mem[2] <= 16'h1111;
      mem[3] <= 16'h00A5;
      mem[4] <= 16'h4444;
      mem[7] <= 16'h7777;
    end else if (sig_mem_write) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (gnt == 2'b11) bad_gnt++;
      if (sig_mem_read && sig_mem_write) bad_strb++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One single-port transaction with checks in ACCESS, RESP and the idle after.
  task automatic txn(input int p, input logic w, input logic [2:0] a,
                     input logic [15:0] d, input logic [15:0] exp_rd);
    logic [1:0] m;
    m   = 2'(1 << p);
    req = m;
    we  = w ? m : 2'b00;
    if (p == 0) begin addr0 = a; wdata0 = d; end
    else        begin addr1 = a; wdata1 = d; end
    tick;
    chk("acc_gnt", gnt, m);
    chk("acc_wr", sig_mem_write, w);
    chk("acc_rd", sig_mem_read, !w);
    chk("acc_addr", mem_addr, a);
    chk("acc_busy", busy, 1);
    if (w) chk("acc_wdata", mem_wdata, d);
    tick;
    chk("resp_ack", ack, m);
    chk("resp_wr", sig_mem_write, 0);
    chk("resp_rd", sig_mem_read, 0);
    chk("resp_rdata", rdata, exp_rd);
    req = 2'b00;
    we  = 2'b00;
    tick;
    chk("idle_ack", ack, 0);
    chk("idle_gnt", gnt, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    rst = 1'b1; req = 0; we = 0; addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    tick; tick;
    chk("rst_gnt", gnt, 0);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wr", sig_mem_write, 0);
    chk("rst_rd", sig_mem_read, 0);
    rst = 1'b0;

    // Reset in the middle of a write's ACCESS cycle
    req = 2'b01; we = 2'b01; addr0 = 3'd1; wdata0 = 16'hDEAD;
    tick;
    chk("mid_wr_on", sig_mem_write, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_wr_drop", sig_mem_write, 0);
    chk("mid_busy", busy, 0);
    chk("mid_gnt", gnt, 0);
    tick;
    chk("mid_noack", ack, 0);
    req = 0; we = 0; rst = 1'b0;
    tick;
    txn(0, 1'b0, 3'd0, 16'h0000, 16'h0A0A);

    // Write then read back through port 0
    txn(0, 1'b1, 3'd5, 16'hBEEF, 16'h0A0A);
    txn(0, 1'b0, 3'd5, 16'h0000, 16'hBEEF);

    // Tie straight after reset: port 0 first, port 1 three cycles later
    rst = 1'b1; tick; rst = 1'b0;
    req = 2'b11; we = 2'b00; addr0 = 3'd2; addr1 = 3'd7;
    tick;
    chk("tie_gnt0", gnt, 2'b01);
    chk("tie_addr0", mem_addr, 2);
    tick;
    chk("tie_ack0", ack, 2'b01);
    chk("tie_rdata0", rdata, 16'h1111);
    req = 2'b10;
    tick;
    chk("tie_idle_gnt", gnt, 0);
    tick;
    chk("tie_gnt1", gnt, 2'b10);
    chk("tie_addr1", mem_addr, 7);
    tick;
    chk("tie_ack1", ack, 2'b10);
    chk("tie_rdata1", rdata, 16'h7777);
    req = 2'b00;
    tick;

    // Continuous tie for 12 cycles: four acks alternating ports
    req = 2'b11; we = 2'b00; addr0 = 3'd2; addr1 = 3'd7;
    nacks = 0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (ack != 2'b00) begin
        chk($sformatf("rr_ack%0d", nacks), ack, (nacks % 2 == 1) ? 2'b10 : 2'b01);
        chk($sformatf("rr_rdata%0d", nacks), rdata, (nacks % 2 == 1) ? 16'h7777 : 16'h1111);
        nacks++;
      end
    end
    req = 2'b00;
    tick;
    chk("rr_count", nacks, 4);

    // rdata survives a write and idle cycles
    txn(0, 1'b0, 3'd3, 16'h0000, 16'h00A5);
    txn(0, 1'b1, 3'd3, 16'h1234, 16'h00A5);
    tick;
    chk("hold_rdata", rdata, 16'h00A5);
    chk("mem3_written", mem[3], 16'h1234);

    // Address change after grant is ignored
    req = 2'b10; we = 2'b00; addr1 = 3'd4;
    tick;
    chk("lat_addr_acc", mem_addr, 4);
    addr1 = 3'd6;
    tick;
    chk("lat_addr_resp", mem_addr, 4);
    chk("lat_ack", ack, 2'b10);
    chk("lat_rdata", rdata, 16'h4444);
    req = 2'b00;
    tick;

    chk("gnt_onehot", bad_gnt, 0);
    chk("strobe_excl", bad_strb, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
